// File: rtl/cpu1.sv
// cpu1: parametrised multicycle fetch/execute core with a single req/ack
// memory port, run/step debug control and a combinational register readout.
module cpu1 #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NREG     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              run,
    input  logic              step,
    input  logic [3:0]        reg_sel,
    output logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              c,
    output logic              z,
    output logic              v,
    output logic              s,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_MVRR = 4'h4, OP_MVRD = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
        OP_JR   = 4'h8, OP_JRC = 4'h9, OP_JRZ = 4'hA, OP_INC = 4'hB,
        OP_HLT  = 4'hF
    } op_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic                r_c, r_z, r_v, r_s;
    logic                r_step;

    logic [3:0]          w_op, w_dr, w_sr;
    logic [7:0]          w_off;
    logic [DATA_W-1:0]   w_rf [16];
    logic [DATA_W-1:0]   w_a, w_b, w_addend, w_res;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_jt;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_cn, w_vn, w_flag_en, w_alu_wr, w_jump;
    logic                w_ack, w_fetch_ack, w_we;
    logic [DATA_W-1:0]   w_wdata;

    assign w_op  = r_ir[15:12];
    assign w_dr  = r_ir[11:8];
    assign w_sr  = r_ir[7:4];
    assign w_off = r_ir[7:0];

    // Indices at or above NREG read as zero and have no storage, so writes vanish.
    for (genvar g = 0; g < 16; g++) begin : g_rf
        if (g < NREG) begin : g_real
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk) begin
                if (reset)
                    r_q <= '0;
                else if (w_we && w_dr == 4'(g))
                    r_q <= w_wdata;
            end
            assign w_rf[g] = r_q;
        end else begin : g_none
            assign w_rf[g] = '0;
        end
    end

    assign w_a      = w_rf[w_dr];
    assign w_b      = w_rf[w_sr];
    assign w_addend = (w_op == OP_INC) ? DATA_W'(1) : w_b;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_addend};
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_jt     = DATA_W'(r_pc) + {{(DATA_W-8){w_off[7]}}, w_off};

    always_comb begin
        w_res     = '0;
        w_cn      = 1'b0;
        w_vn      = 1'b0;
        w_flag_en = 1'b0;
        w_alu_wr  = 1'b0;
        case (w_op)
            OP_ADD, OP_INC: begin
                w_res     = w_sum[DATA_W-1:0];
                w_cn      = w_sum[DATA_W];
                w_vn      = (w_a[DATA_W-1] == w_addend[DATA_W-1]) &&
                            (w_res[DATA_W-1] != w_a[DATA_W-1]);
                w_flag_en = 1'b1;
                w_alu_wr  = 1'b1;
            end
            OP_SUB: begin
                w_res     = w_a - w_b;
                w_cn      = (w_a < w_b);
                w_vn      = (w_a[DATA_W-1] != w_b[DATA_W-1]) &&
                            (w_res[DATA_W-1] != w_a[DATA_W-1]);
                w_flag_en = 1'b1;
                w_alu_wr  = 1'b1;
            end
            OP_AND: begin
                w_res     = w_a & w_b;
                w_flag_en = 1'b1;
                w_alu_wr  = 1'b1;
            end
            OP_MVRR: begin
                w_res    = w_b;
                w_alu_wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_jump = (w_op == OP_JR) || (w_op == OP_JRC && r_c) || (w_op == OP_JRZ && r_z);

    // Request is combinational so it drops in the very cycle reset rises.
    assign mem_req     = !reset && ((r_state == S_FETCH && (run || r_step)) || r_state == S_MEM);
    assign mem_we      = !reset && r_state == S_MEM && w_op == OP_STR;
    assign mem_wdata   = w_b;
    assign w_ack       = mem_req && mem_ack;
    assign w_fetch_ack = w_ack && r_state == S_FETCH;

    always_comb begin
        mem_addr = r_pc;
        if (r_state == S_MEM) begin
            if (w_op == OP_LDR)
                mem_addr = w_b[ADDR_W-1:0];
            else if (w_op == OP_STR)
                mem_addr = w_a[ADDR_W-1:0];
        end
    end

    assign w_we = (r_state == S_EXEC && w_alu_wr) ||
                  (r_state == S_MEM && w_ack && (w_op == OP_LDR || w_op == OP_MVRD));
    assign w_wdata = (r_state == S_MEM) ? mem_rdata : w_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= ADDR_W'(RESET_PC);
            r_ir    <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_s     <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            // A pulse coinciding with the clearing ack is absorbed, not queued.
            if (w_fetch_ack)
                r_step <= 1'b0;
            else if (step && !run)
                r_step <= 1'b1;

            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        r_ir    <= mem_rdata[15:0];
                        r_pc    <= w_pc_inc;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_flag_en) begin
                        r_c <= w_cn;
                        r_v <= w_vn;
                        r_z <= (w_res == '0);
                        r_s <= w_res[DATA_W-1];
                    end
                    if (w_jump)
                        r_pc <= w_jt[ADDR_W-1:0];
                    case (w_op)
                        OP_MVRD, OP_LDR, OP_STR: r_state <= S_MEM;
                        OP_HLT:                  r_state <= S_HALT;
                        default:                 r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (w_ack) begin
                        if (w_op == OP_MVRD)
                            r_pc <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign reg_data = w_rf[reg_sel];
    assign pc_out   = r_pc;
    assign c        = r_c;
    assign z        = r_z;
    assign v        = r_v;
    assign s        = r_s;
    assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu1.sv
// Bench for cpu1: memory model with programmable wait states, an access
// scoreboard checked by a monitor, and directed program checks.
module tb_cpu1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  reg_sel = 4'd0;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, reg_data, pc_out;
    logic        c, z, v, s, halted;

    int checks = 0;
    int failures = 0;

    logic [15:0] prog [256];
    int unsigned wait_n = 0;
    int unsigned wcnt = 0;
    int unsigned n_writes = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;
    acc_t expq[$];

    always #5 clk = ~clk;

    cpu1 #(.DATA_W(16), .ADDR_W(16), .NREG(8), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .run(run), .step(step), .reg_sel(reg_sel), .reg_data(reg_data),
        .pc_out(pc_out), .c(c), .z(z), .v(v), .s(s), .halted(halted)
    );

    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = prog[mem_addr[7:0]];

    always @(posedge clk) begin
        if (reset || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!reset && mem_req && mem_ack && mem_we) n_writes <= n_writes + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input logic [3:0] sel, input logic [15:0] exp, input string name);
        reg_sel = sel;
        #1;
        chk(name, 32'(reg_data), 32'(exp));
    endtask

    task automatic push_rd(input logic [15:0] a);
        expq.push_back('{we: 1'b0, addr: a, data: 16'h0});
    endtask

    task automatic begin_test(input int unsigned w);
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        wait_n = w;
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
        tick(2);
    endtask

    task automatic release_reset(input logic r);
        run   = r;
        reset = 1'b0;
    endtask

    task automatic end_test(input string name);
        chk(name, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic wait_halt(input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            tick(1);
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    // Monitor: pops the expected access on every ack and checks that the
    // request is frozen across wait cycles.
    initial begin
        logic        pw;
        logic        pwe;
        logic [15:0] pa;
        acc_t        e;
        pw = 1'b0;
        pwe = 1'b0;
        pa = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pw = 1'b0;
            end else begin
                if (pw) begin
                    chk("wait_req_held", 32'(mem_req), 32'd1);
                    chk("wait_addr_held", 32'(mem_addr), 32'(pa));
                    chk("wait_we_held", 32'(mem_we), 32'(pwe));
                end
                if (mem_req && mem_ack) begin
                    chk("acc_expected", 32'(expq.size() != 0), 32'd1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("acc_addr", 32'(mem_addr), 32'(e.addr));
                        chk("acc_we", 32'(mem_we), 32'(e.we));
                        if (e.we) chk("acc_wdata", 32'(mem_wdata), 32'(e.data));
                    end
                end
                pw  = mem_req && !mem_ack;
                pa  = mem_addr;
                pwe = mem_we;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int reqs;
        int unsigned nw0;

        // Reset state, then MVRD r1,#7FFF ; INC r1 ; HLT
        begin_test(0);
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_flags", 32'({c, z, v, s}), 32'h0);
        chk_reg(4'd1, 16'h0, "rst_r1");
        prog[0] = 16'h5100; prog[1] = 16'h7FFF; prog[2] = 16'hB100; prog[3] = 16'hF000;
        push_rd(16'd0); push_rd(16'd1); push_rd(16'd2); push_rd(16'd3);
        release_reset(1'b1);
        tick(3);
        chk("mvrd_pc", 32'(pc_out), 32'd2);
        chk_reg(4'd1, 16'h7FFF, "mvrd_r1");
        tick(2);
        chk("inc_pc", 32'(pc_out), 32'd3);
        chk_reg(4'd1, 16'h8000, "inc_r1");
        chk("inc_flags_czvs", 32'({c, z, v, s}), 32'b0011);
        wait_halt(20);
        end_test("t1_drained");

        // SUB borrow then AND zero
        begin_test(0);
        prog[0] = 16'h5200; prog[1] = 16'h0001; prog[2] = 16'h5300; prog[3] = 16'h0002;
        prog[4] = 16'h2230; prog[5] = 16'h3200; prog[6] = 16'hF000;
        for (int i = 0; i < 7; i++) push_rd(16'(i));
        release_reset(1'b1);
        tick(8);
        chk_reg(4'd2, 16'hFFFF, "sub_r2");
        chk("sub_flags_czvs", 32'({c, z, v, s}), 32'b1001);
        tick(2);
        chk_reg(4'd2, 16'h0000, "and_r2");
        chk("and_flags_czvs", 32'({c, z, v, s}), 32'b0100);
        wait_halt(20);
        end_test("t2_drained");

        // LDR with 3 wait cycles on every access
        begin_test(3);
        prog[0] = 16'h5500; prog[1] = 16'h0010; prog[2] = 16'h6450; prog[3] = 16'hF000;
        prog[16] = 16'hBEEF;
        push_rd(16'd0); push_rd(16'd1); push_rd(16'd2); push_rd(16'h0010); push_rd(16'd3);
        release_reset(1'b1);
        tick(9);
        chk_reg(4'd5, 16'h0010, "wait_mvrd_r5");
        tick(8);
        chk_reg(4'd4, 16'h0000, "ldr_not_early");
        tick(1);
        chk_reg(4'd4, 16'hBEEF, "ldr_r4");
        wait_halt(40);
        end_test("t3_drained");

        // JRZ -2 taken (z=1)
        begin_test(0);
        prog[0] = 16'h3000; prog[1] = 16'h8003; prog[5] = 16'hA0FE; prog[4] = 16'hF000;
        prog[6] = 16'h0000;
        push_rd(16'd0); push_rd(16'd1); push_rd(16'd5); push_rd(16'd4);
        release_reset(1'b1);
        wait_halt(30);
        chk("jrz_taken_pc", 32'(pc_out), 32'd5);
        end_test("t4_drained");

        // JRZ -2 not taken (z=0)
        begin_test(0);
        prog[0] = 16'hB100; prog[1] = 16'h8003; prog[5] = 16'hA0FE; prog[4] = 16'h0000;
        push_rd(16'd0); push_rd(16'd1); push_rd(16'd5); push_rd(16'd6);
        release_reset(1'b1);
        wait_halt(30);
        chk("jrz_fall_pc", 32'(pc_out), 32'd7);
        end_test("t5_drained");

        // Step mode: three pulses, the last two cycles wide (second cycle absorbed)
        begin_test(0);
        for (int i = 0; i < 8; i++) prog[i] = 16'hB100;
        push_rd(16'd0); push_rd(16'd1); push_rd(16'd2);
        release_reset(1'b0);
        tick(3);
        chk("idle_no_req", 32'(mem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick((k == 2) ? 2 : 1);
            step = 1'b0;
            tick((k == 2) ? 1 : 2);
            reqs = 0;
            for (int j = 0; j < 7; j++) begin
                if (mem_req) reqs++;
                tick(1);
            end
            chk("step_gap_no_req", 32'(reqs), 32'd0);
        end
        chk("step_pc", 32'(pc_out), 32'd3);
        chk_reg(4'd1, 16'h0003, "step_r1");
        end_test("t6_drained");

        // HLT at 0, no requests while halted, reset recovers
        begin_test(0);
        push_rd(16'd0);
        release_reset(1'b1);
        wait_halt(20);
        chk("hlt_pc", 32'(pc_out), 32'd1);
        reqs = 0;
        for (int j = 0; j < 10; j++) begin
            if (mem_req) reqs++;
            tick(1);
        end
        chk("hlt_no_req", 32'(reqs), 32'd0);
        reset = 1'b1;
        run = 1'b0;
        tick(2);
        chk("hlt_reset_pc", 32'(pc_out), 32'd0);
        chk("hlt_reset_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("hlt_after_release", 32'(halted), 32'd0);
        end_test("t7_drained");

        // Reset during an STR wait cycle abandons the write
        begin_test(3);
        prog[0] = 16'h5100; prog[1] = 16'h0020; prog[2] = 16'h5200; prog[3] = 16'h1234;
        prog[4] = 16'h7120;
        for (int i = 0; i < 5; i++) push_rd(16'(i));
        nw0 = n_writes;
        release_reset(1'b1);
        tick(24);
        chk("str_req", 32'(mem_req), 32'd1);
        chk("str_we", 32'(mem_we), 32'd1);
        chk("str_addr", 32'(mem_addr), 32'h0020);
        chk("str_wdata", 32'(mem_wdata), 32'h1234);
        reset = 1'b1;
        run = 1'b0;
        #1;
        chk("str_abort_req", 32'(mem_req), 32'd0);
        chk("str_abort_we", 32'(mem_we), 32'd0);
        tick(3);
        chk("str_no_write", 32'(n_writes), 32'(nw0));
        chk("str_reset_pc", 32'(pc_out), 32'd0);
        end_test("t8_drained");

        // Register indices beyond NREG: write discarded, read as zero
        begin_test(0);
        prog[0] = 16'h5300; prog[1] = 16'h0007; prog[2] = 16'h5900; prog[3] = 16'h5555;
        prog[4] = 16'h4390; prog[5] = 16'hF000;
        for (int i = 0; i < 6; i++) push_rd(16'(i));
        release_reset(1'b1);
        wait_halt(30);
        chk_reg(4'd9, 16'h0000, "r9_reads_zero");
        chk_reg(4'd3, 16'h0000, "mvrr_from_r9");
        end_test("t9_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
